// File: rtl/dpram_pkg.sv
// dpram_pkg: shared defaults and helpers for the dual-port-RAM FIFO controller.
// Holds the default data/address widths, the derived depth, the almost-flag
// thresholds used when DPRAM_FIFO_ALMOST_EN is defined, and a small helper
// that classifies a counter update from its increment/decrement requests.
package dpram_pkg;

   localparam int DEF_DATA_W         = 8;
   localparam int DEF_ADDR_W         = 6;
   localparam int DEF_DEPTH          = 2 ** DEF_ADDR_W;

   localparam int ALMOST_FULL_MARGIN = 4;
   localparam int ALMOST_EMPTY_LEVEL = 4;

   localparam int OBUF_ENTRIES       = 2;

   typedef enum logic [1:0] {
      STEP_HOLD,
      STEP_UP,
      STEP_DOWN
   } count_step_e;

   // Simultaneous increment and decrement cancel out.
   function automatic count_step_e count_step(input logic inc, input logic dec);
      count_step_e step;
      step = STEP_HOLD;
      if (inc && !dec) begin
         step = STEP_UP;
      end else if (dec && !inc) begin
         step = STEP_DOWN;
      end
      return step;
   endfunction

endpackage

// File: rtl/dpram_fifo_obuf.sv
// dpram_fifo_obuf: two-entry output buffer with valid/ready on its read side.
// Words arrive from the RAM read port one clock after the read was issued.
// The controller guarantees a write never lands while both entries are held,
// so the entry presented on rd_data is never overwritten while it waits.
module dpram_fifo_obuf
   import dpram_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              rd_ready,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] entry [OBUF_ENTRIES];
   logic              wr_sel;
   logic              rd_sel;
   logic [1:0]        cnt;
   logic              pop;

   assign pop      = (cnt != 2'd0) && rd_ready;
   assign rd_valid = (cnt != 2'd0);
   assign rd_data  = entry[rd_sel];
   assign count    = cnt;

   // Storage is cleared on reset so the read data idles at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry[0] <= '0;
         entry[1] <= '0;
      end else if (wr_en) begin
         entry[wr_sel] <= wr_data;
      end
   end

   // Write and read selectors ping-pong between the two entries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_sel <= 1'b0;
         rd_sel <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_sel <= ~wr_sel;
         end
         if (pop) begin
            rd_sel <= ~rd_sel;
         end
      end
   end

   // Fill level of the buffer, used by the controller for read credit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 2'd0;
      end else begin
         case (count_step(wr_en, pop))
            STEP_UP:   cnt <= cnt + 2'd1;
            STEP_DOWN: cnt <= cnt - 2'd1;
            default:   cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: FIFO controller wrapped around an external dual-port RAM.
// Port A of the RAM is the write side, port B the read side (one-clock read
// latency). Read data lands in a two-entry output buffer so that the
// downstream side sees a registered valid/ready stream at one word per clock.
// Optional feature macro: DPRAM_FIFO_ALMOST_EN adds almost_full/almost_empty.
module dpram_fifo_ctrl
   import dpram_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready,
   output logic [DATA_W-1:0] ram_ip_a,
   output logic [ADDR_W-1:0] ram_add_a,
   output logic              ram_wr_a,
   output logic [DATA_W-1:0] ram_ip_b,
   output logic [ADDR_W-1:0] ram_add_b,
   output logic              ram_wr_b,
   input  logic [DATA_W-1:0] ram_q_b,
   output logic [ADDR_W:0]   occupancy
`ifdef DPRAM_FIFO_ALMOST_EN
   ,
   output logic              almost_full,
   output logic              almost_empty
`endif
);

   localparam int              DEPTH      = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] CNT_ONE    = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   logic [ADDR_W-1:0] wptr;
   logic [ADDR_W-1:0] rptr;
   logic [ADDR_W:0]   ram_count;
   logic              in_flight;
   logic [1:0]        obuf_count;
   logic [2:0]        credit;
   logic              accept;
   logic              pop;
   logic              issue;

   // Reset forces s_ready low directly so nothing is accepted while held.
   assign s_ready = rst_n && (occupancy != FULL_LEVEL);
   assign accept  = s_valid && s_ready;
   assign pop     = m_valid && m_ready;

   // Free output slots once this cycle's pop and the in-flight word settle.
   // Counting the pop lets a read issue in the same cycle a slot is vacated,
   // which is what keeps the stream at one word per clock.
   assign credit = 3'(OBUF_ENTRIES) - {1'b0, obuf_count} + {2'b0, pop}
                   - {2'b0, in_flight};
   assign issue  = (ram_count != '0) && (credit != 3'd0);

   assign ram_wr_a  = accept;
   assign ram_add_a = wptr;
   assign ram_ip_a  = s_data;

   // Port B is read-only.
   assign ram_add_b = rptr;
   assign ram_wr_b  = 1'b0;
   assign ram_ip_b  = '0;

   // Write pointer advances per accepted word and wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
      end else if (accept) begin
         wptr <= wptr + PTR_ONE;
      end
   end

   // Read pointer advances per issued read; in_flight marks data due next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rptr      <= '0;
         in_flight <= 1'b0;
      end else begin
         in_flight <= issue;
         if (issue) begin
            rptr <= rptr + PTR_ONE;
         end
      end
   end

   // Unread words still sitting in the RAM; a word becomes readable the
   // cycle after it is written because this count only rises at that edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_count <= '0;
      end else begin
         case (count_step(accept, issue))
            STEP_UP:   ram_count <= ram_count + CNT_ONE;
            STEP_DOWN: ram_count <= ram_count - CNT_ONE;
            default:   ram_count <= ram_count;
         endcase
      end
   end

   // Total words held: RAM, in flight and in the output buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occupancy <= '0;
      end else begin
         case (count_step(accept, pop))
            STEP_UP:   occupancy <= occupancy + CNT_ONE;
            STEP_DOWN: occupancy <= occupancy - CNT_ONE;
            default:   occupancy <= occupancy;
         endcase
      end
   end

   // Stale RAM data returning after a reset is ignored since in_flight is clear.
   dpram_fifo_obuf #(
      .DATA_W (DATA_W)
   ) u_obuf (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (in_flight),
      .wr_data  (ram_q_b),
      .rd_valid (m_valid),
      .rd_data  (m_data),
      .rd_ready (m_ready),
      .count    (obuf_count)
   );

`ifdef DPRAM_FIFO_ALMOST_EN
   // Flags derive straight from the occupancy register.
   assign almost_full  = (occupancy >= (ADDR_W+1)'(DEPTH - ALMOST_FULL_MARGIN));
   assign almost_empty = (occupancy <= (ADDR_W+1)'(ALMOST_EMPTY_LEVEL));
`else
   // Almost flags are not built in this configuration.
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb_dpram_fifo_ctrl: scoreboard bench for dpram_fifo_ctrl with a behavioural
// synchronous dual-port RAM. Accepted words are queued with the edge they were
// written on; a negedge monitor checks m_valid timing, m_data order and
// stability, occupancy and the RAM write port against that model.
// Define DPRAM_FIFO_ALMOST_EN to also exercise the almost flags.
module tb_dpram_fifo_ctrl;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 6;
   localparam int DEPTH  = 64;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              s_valid = 1'b0;
   logic [DATA_W-1:0] s_data = '0;
   logic              s_ready;
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   logic              m_ready = 1'b0;
   logic [DATA_W-1:0] ram_ip_a;
   logic [ADDR_W-1:0] ram_add_a;
   logic              ram_wr_a;
   logic [DATA_W-1:0] ram_ip_b;
   logic [ADDR_W-1:0] ram_add_b;
   logic              ram_wr_b;
   logic [DATA_W-1:0] ram_q_b;
   logic [ADDR_W:0]   occupancy;
`ifdef DPRAM_FIFO_ALMOST_EN
   logic              almost_full;
   logic              almost_empty;
`endif

   typedef struct {
      logic [DATA_W-1:0] data;
      int                t;
   } sb_entry_t;

   sb_entry_t         sb[$];
   int                tests = 0;
   int                fails = 0;
   int                cyc = 0;
   int                model_occ = 0;
   logic [ADDR_W-1:0] model_wptr = '0;
   logic              last_acc = 1'b0;
   logic              stall_prev = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;
   logic              exp_mvalid;
   logic              exp_wr;
   logic [DATA_W-1:0] next_word;
   logic              found;
   logic [DATA_W-1:0] mem [DEPTH];

   always #5 clk = ~clk;

   dpram_fifo_ctrl #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .m_ready   (m_ready),
      .ram_ip_a  (ram_ip_a),
      .ram_add_a (ram_add_a),
      .ram_wr_a  (ram_wr_a),
      .ram_ip_b  (ram_ip_b),
      .ram_add_b (ram_add_b),
      .ram_wr_b  (ram_wr_b),
      .ram_q_b   (ram_q_b),
      .occupancy (occupancy)
`ifdef DPRAM_FIFO_ALMOST_EN
      ,
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
`endif
   );

   // Behavioural dual-port RAM: port A writes, port B reads with one-clock latency.
   always @(posedge clk) begin
      if (ram_wr_a) begin
         mem[ram_add_a] <= ram_ip_a;
      end
      ram_q_b <= mem[ram_add_b];
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [DATA_W-1:0] data,
                                input logic ready);
      @(posedge clk);
      #1;
      s_valid = valid;
      s_data  = data;
      m_ready = ready;
   endtask

   // mode 0: m_ready low, 1: m_ready high, 2: m_ready toggling 1010...
   task automatic stream_words(input int n, input int mode);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b1, next_word,
                       (mode == 1) ? 1'b1 : ((mode == 2) ? ((i % 2) == 0) : 1'b0));
         @(negedge clk);
         #1;
         if (last_acc) begin
            next_word = next_word + 8'd1;
         end
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 150 && model_occ != 0; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1);
      end
      applyStimulus(1'b0, 8'h00, 1'b1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      #1;
      checkOutput("drained_occupancy", occupancy, 0);
      checkOutput("drained_m_valid", m_valid, 0);
   endtask

   // Monitor: compares DUT outputs to the scoreboard, then advances the model.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         sb.delete();
         model_occ  = 0;
         model_wptr = '0;
         stall_prev = 1'b0;
         last_acc   = 1'b0;
      end else begin
         exp_mvalid = (sb.size() > 0) && (sb[0].t + 2 <= cyc);
         checkOutput("m_valid", m_valid, exp_mvalid);
         if (m_valid && exp_mvalid) begin
            checkOutput("m_data", m_data, sb[0].data);
         end
         if (stall_prev) begin
            checkOutput("m_data_stable", m_data, prev_data);
         end
         checkOutput("occupancy", occupancy, model_occ);
         checkOutput("s_ready", s_ready, model_occ != DEPTH);
         exp_wr = s_valid && (model_occ != DEPTH);
         checkOutput("ram_wr_a", ram_wr_a, exp_wr);
         if (exp_wr) begin
            checkOutput("ram_add_a", ram_add_a, model_wptr);
            checkOutput("ram_ip_a", ram_ip_a, s_data);
         end
         checkOutput("ram_wr_b", ram_wr_b, 0);
         stall_prev = m_valid && !m_ready;
         prev_data  = m_data;
         if (m_valid && m_ready) begin
            checkOutput("pop_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               void'(sb.pop_front());
               model_occ--;
            end
         end
         if (exp_wr) begin
            sb.push_back('{s_data, cyc + 1});
            model_occ++;
            model_wptr = model_wptr + 6'd1;
         end
         last_acc = exp_wr;
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #1 rst_n = 1'b0;
      #7;
      checkOutput("rst_m_valid", m_valid, 0);
      checkOutput("rst_s_ready", s_ready, 0);
      checkOutput("rst_occupancy", occupancy, 0);
      checkOutput("rst_ram_wr_a", ram_wr_a, 0);
      checkOutput("rst_ram_add_a", ram_add_a, 0);
      checkOutput("rst_ram_add_b", ram_add_b, 0);
      checkOutput("rst_m_data", m_data, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      s_valid = 1'b1;
      s_data = 8'h01;
      m_ready = 1'b1;

      // Three back-to-back words; first m_valid two clocks after first accept.
      applyStimulus(1'b1, 8'h02, 1'b1);
      applyStimulus(1'b1, 8'h03, 1'b1);
      checkOutput("latency_early", m_valid, 0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("latency_first", m_valid, 1);
      checkOutput("latency_first_data", m_data, 8'h01);
      drain();

      // Fill to 64, then attempt a 65th word.
      next_word = 8'h00;
      stream_words(64, 0);
      applyStimulus(1'b1, next_word, 1'b0);
      #1;
      checkOutput("full_occupancy", occupancy, 64);
      checkOutput("full_s_ready", s_ready, 0);
      checkOutput("full_no_write", ram_wr_a, 0);
      @(negedge clk);
      #1;

      // Stream through pointer wrap, then with a toggling consumer.
      stream_words(80, 1);
      stream_words(40, 2);
      drain();

      // Reset mid-cycle with ten words held.
      next_word = 8'h10;
      stream_words(10, 0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      #1;
      checkOutput("pre_reset_occupancy", occupancy, 10);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_m_valid", m_valid, 0);
      checkOutput("midrst_occupancy", occupancy, 0);
      checkOutput("midrst_s_ready", s_ready, 0);
      checkOutput("midrst_ram_wr_a", ram_wr_a, 0);
      checkOutput("midrst_m_data", m_data, 0);
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      s_valid = 1'b1;
      s_data = 8'hA5;
      m_ready = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         #1;
         if (m_valid) begin
            found = 1'b1;
         end
      end
      checkOutput("post_reset_seen", found, 1);
      if (found) begin
         checkOutput("post_reset_first", m_data, 8'hA5);
      end
      drain();

`ifdef DPRAM_FIFO_ALMOST_EN
      // Threshold crossings of the almost flags.
      next_word = 8'h80;
      stream_words(4, 0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      #1;
      checkOutput("almost_empty_at_4", almost_empty, 1);
      checkOutput("almost_full_at_4", almost_full, 0);
      stream_words(1, 0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      #1;
      checkOutput("almost_empty_at_5", almost_empty, 0);
      stream_words(54, 0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      #1;
      checkOutput("almost_full_at_59", almost_full, 0);
      stream_words(1, 0);
      applyStimulus(1'b0, 8'h00, 1'b0);
      #1;
      checkOutput("almost_full_at_60", almost_full, 1);
      drain();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
